regfile_mp: RTL and testbench

Parametrised successor to the core's 32x32 register file: configurable width, depth and read-port count, architectural zero register, optional write-to-read bypass, per-register busy scoreboard for a pipelined core, and a synchronous reset that clears the array sequentially so storage can map to LUTRAM. Sits in the decode stage between the instruction decoder (read addresses, issue) and writeback (write port).

---
 rtl/regfile_pkg.sv | 6 +
 rtl/regfile_scoreboard.sv | 29 ++
 rtl/regfile_mp.sv | 67 ++++++
 tb/tb_regfile_mp.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizes for regfile_mp
package regfile_pkg;
  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREG busy bits (set beats clear, bit 0 pinned low); clk/rst, i_set/i_set_addr, i_clr/i_clr_addr, i_ra lookups -> o_busy
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int NUM_RD = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set,
  input  logic [AW-1:0]        i_set_addr,
  input  logic                 i_clr,
  input  logic [AW-1:0]        i_clr_addr,
  input  logic [NUM_RD*AW-1:0] i_ra,
  output logic [NUM_RD-1:0]    o_busy
);
  logic [NREG-1:0] r_busy, w_busy_nx;
  always_comb begin
    w_busy_nx = r_busy;
    if (i_clr) w_busy_nx[i_clr_addr] = 1'b0;
    if (i_set) w_busy_nx[i_set_addr] = 1'b1;
    w_busy_nx[0] = 1'b0;
  end
  always_ff @(posedge clk) r_busy <= rst ? '0 : w_busy_nx;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_lk
    assign o_busy[i] = r_busy[i_ra[i*AW +: AW]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: register file with zero reg, optional bypass, busy scoreboard, sequential clear; clk/rst, ra->rd/rbusy, we/wa/wd, sb_set/sb_addr, ready
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   ra,
  output logic [NUM_RD*XLEN-1:0] rd,
  output logic [NUM_RD-1:0]      rbusy,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [XLEN-1:0]        wd,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_addr,
  output logic                   ready
);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  rf_state_t r_state, w_state_nx;
  logic [AW-1:0] r_idx;
  logic r_ready;
  logic [XLEN-1:0] r_mem [NREG];
  logic w_run, w_wr, w_mem_we;
  logic [AW-1:0] w_mem_a;
  logic [NUM_RD-1:0] w_sb_busy;
  assign w_run = r_state == RF_RUN;
  assign w_wr = w_run && we && wa != '0;
  assign ready = r_ready;
  always_comb w_state_nx = (r_state == RF_CLEAR && r_idx == LAST) ? RF_RUN : r_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_CLEAR;
      r_idx   <= AW'(1);
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_run ? r_idx : r_idx + 1'b1;
      r_ready <= w_state_nx == RF_RUN;
    end
  end
  assign w_mem_we = !rst && (!w_run || w_wr);
  assign w_mem_a = w_run ? wa : r_idx;
  always_ff @(posedge clk) if (w_mem_we) r_mem[w_mem_a] <= w_run ? wd : '0;
  regfile_scoreboard #(.NREG(NREG), .NUM_RD(NUM_RD)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set      (w_run && sb_set && sb_addr != '0),
    .i_set_addr (sb_addr),
    .i_clr      (w_wr),
    .i_clr_addr (wa),
    .i_ra       (ra),
    .o_busy     (w_sb_busy)
  );
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] w_a;
    logic w_byp;
    assign w_a = ra[i*AW +: AW];
    assign w_byp = BYPASS != 0 && we && wa == w_a;
    assign rd[i*XLEN +: XLEN] = (!w_run || w_a == '0) ? '0 : w_byp ? wd : r_mem[w_a];
    assign rbusy[i] = w_run && w_a != '0 && !w_byp && w_sb_busy[i];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp with BYPASS=1 and BYPASS=0 instances sharing stimulus
module tb_regfile_mp;
  logic clk = 0, rst = 1, we = 0, sb_set = 0;
  logic [9:0] ra = '0;
  logic [4:0] wa = '0, sb_addr = '0;
  logic [31:0] wd = '0;
  logic [63:0] rd1, rd0;
  logic [1:0] rb1, rb0;
  logic rdy1, rdy0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  regfile_mp #(.BYPASS(1)) u_b1 (.clk(clk), .rst(rst), .ra(ra), .rd(rd1), .rbusy(rb1), .we(we),
    .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr), .ready(rdy1));
  regfile_mp #(.BYPASS(0)) u_b0 (.clk(clk), .rst(rst), .ra(ra), .rd(rd0), .rbusy(rb0), .we(we),
    .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr), .ready(rdy0));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rd_both(input logic [4:0] a);
    ra = {a, a};
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; wa = a; wd = d;
    step();
    we = 0;
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!rdy1 && n < 100) begin
      step();
      n++;
    end
    check(tag, n, 31);
    check({tag, "_b0"}, rdy0, 1);
  endtask
  initial begin
    step();
    step();
    check("reset_ready", rdy1, 0);
    rst = 0;
    we = 1; wa = 5; wd = 32'hDEAD;
    rd_both(5);
    for (int k = 1; k <= 31; k++) begin
      check("clear_rd0", rd1[31:0], 0);
      check("clear_rd1", rd1[63:32], 0);
      check("clear_rbusy", rb1, 0);
      step();
      check("clear_ready", rdy1, k == 31);
    end
    we = 0;
    check("ready_b0", rdy0, 1);
    for (int r = 1; r < 32; r++) begin
      rd_both(r[4:0]);
      check("zero_after_clear", rd1[31:0], 0);
      check("zero_after_clear_b0", rd0[63:32], 0);
    end
    wr(7, 32'h12345678);
    rd_both(7);
    check("rd7_p0", rd1[31:0], 32'h12345678);
    check("rd7_p1", rd1[63:32], 32'h12345678);
    check("rd7_b0_p1", rd0[63:32], 32'h12345678);
    we = 1; wa = 0; wd = 32'hFFFFFFFF;
    rd_both(0);
    check("x0_bypass", rd1[31:0], 0);
    step();
    we = 0;
    #1;
    check("x0_read", rd1[31:0], 0);
    check("x0_read_b0", rd0[63:32], 0);
    wr(3, 32'h11);
    we = 1; wa = 3; wd = 32'h22;
    rd_both(3);
    check("bypass_on", rd1[31:0], 32'h22);
    check("bypass_off", rd0[31:0], 32'h11);
    step();
    we = 0;
    #1;
    check("bypass_off_next", rd0[31:0], 32'h22);
    sb_set = 1; sb_addr = 9;
    rd_both(9);
    check("sb_before", rb1, 2'b00);
    step();
    sb_set = 0;
    #1;
    check("sb_set_b1", rb1, 2'b11);
    check("sb_set_b0", rb0, 2'b11);
    we = 1; wa = 9; wd = 32'h99;
    #1;
    check("sb_wr_bypass", rb1, 2'b00);
    check("sb_wr_nobypass", rb0, 2'b11);
    step();
    we = 0;
    #1;
    check("sb_clr_b1", rb1, 2'b00);
    check("sb_clr_b0", rb0, 2'b00);
    sb_set = 1; sb_addr = 9; we = 1; wa = 9; wd = 32'h77;
    step();
    sb_set = 0; we = 0;
    #1;
    check("sb_set_wins_b1", rb1, 2'b11);
    check("sb_set_wins_b0", rb0, 2'b11);
    check("sb_set_wins_data", rd0[31:0], 32'h77);
    sb_set = 1; sb_addr = 0;
    step();
    sb_set = 0;
    rd_both(0);
    check("x0_never_busy", rb1, 2'b00);
    sb_set = 1; sb_addr = 4;
    step();
    sb_addr = 5;
    step();
    sb_set = 0;
    wr(4, 32'hAA);
    ra = {5'd5, 5'd4};
    #1;
    check("pre_rst_rd4", rd1[31:0], 32'hAA);
    check("pre_rst_busy", rb1, 2'b10);
    rst = 1;
    we = 1; wa = 4; wd = 32'h55;
    step();
    rst = 0;
    for (int k = 0; k < 10; k++) step();
    check("midclear_ready", rdy1, 0);
    check("midclear_rd", rd1[31:0], 0);
    rst = 1;
    step();
    rst = 0; we = 0;
    wait_ready("restart_ready");
    ra = {5'd5, 5'd4};
    #1;
    check("rst_rd4", rd1[31:0], 0);
    check("rst_rd5", rd1[63:32], 0);
    check("rst_busy_b1", rb1, 2'b00);
    check("rst_busy_b0", rb0, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
